// File: rtl/usb_tx.sv
// Full-speed USB transmitter: SYNC, PID, payload, optional CRC16, bit stuffing,
// NRZI line coding and EOP, one bit every 4 clocks of the 48 MHz core clock.
module usb_tx (
  input  logic       clk_48,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_crc16,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_en,
  output logic       dp_out,
  output logic       dn_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PID     = 3'd2,
    DATA    = 3'd3,
    CRC     = 3'd4,
    EOP_SE0 = 3'd5,
    EOP_J   = 3'd6
  } state_t;

  state_t      r_state;
  logic [1:0]  r_timer;
  logic [3:0]  r_bitcnt;
  logic [2:0]  r_ones;
  logic [7:0]  r_shift;
  logic [3:0]  r_pid;
  logic        r_crc_en;
  logic [15:0] r_crc;
  logic        r_dp;
  logic        r_dn;
  logic        r_en;
  logic        r_busy;
  logic        r_ready;

  logic        w_start;
  logic        w_byte_end;
  logic        w_payload;
  logic        w_to_eop;
  logic        w_crc_upd;
  logic        w_bit;
  logic [3:0]  w_idx;
  logic [7:0]  w_pid_byte;

  // Reflected form of x^16+x^15+x^2+1, fed LSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    crc16_step = {1'b0, crc[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
  endfunction

  assign w_start    = tx_start && ((r_state == IDLE) || ((r_state == EOP_J) && (r_timer == 2'd3)));
  assign w_idx      = r_bitcnt + 4'd1;
  assign w_pid_byte = {~r_pid, r_pid};
  assign w_payload  = (r_state == PID) || (r_state == DATA);
  // A pending stuff bit (six ones) always precedes the end of the field.
  assign w_byte_end = (r_ones != 3'd6) && (r_bitcnt == ((r_state == CRC) ? 4'd15 : 4'd7));
  assign w_to_eop   = w_byte_end && ((r_state == CRC) || (w_payload && !tx_valid && !r_crc_en));
  assign w_crc_upd  = ((r_state == DATA) && (r_ones != 3'd6) && !w_byte_end)
                    || (w_payload && w_byte_end && tx_valid);

  // Next bit to place on the line at the coming bit boundary.
  always_comb begin
    w_bit = 1'b0;
    if (r_ones == 3'd6) begin
      w_bit = 1'b0;
    end else if (!w_byte_end) begin
      case (r_state)
        SYNC:    w_bit = (w_idx[2:0] == 3'd7);
        PID:     w_bit = w_pid_byte[w_idx[2:0]];
        DATA:    w_bit = r_shift[w_idx[2:0]];
        CRC:     w_bit = ~r_crc[w_idx];
        default: w_bit = 1'b0;
      endcase
    end else begin
      case (r_state)
        SYNC:      w_bit = r_pid[0];
        PID, DATA: w_bit = tx_valid ? tx_data[0] : ~r_crc[0];
        default:   w_bit = 1'b0;
      endcase
    end
  end

  // Packet sequencer, bit timer, stuffing, CRC and NRZI line drivers.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= 2'd0;
      r_bitcnt <= 4'd0;
      r_ones   <= 3'd0;
      r_shift  <= 8'd0;
      r_pid    <= 4'd0;
      r_crc_en <= 1'b0;
      r_crc    <= 16'hFFFF;
      r_dp     <= 1'b1;
      r_dn     <= 1'b0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
    end else if (w_start) begin
      // First SYNC bit is a 0, so the line goes straight from J to K.
      r_state  <= SYNC;
      r_timer  <= 2'd0;
      r_bitcnt <= 4'd0;
      r_ones   <= 3'd0;
      r_pid    <= tx_pid;
      r_crc_en <= tx_crc16;
      r_crc    <= 16'hFFFF;
      r_dp     <= 1'b0;
      r_dn     <= 1'b1;
      r_en     <= 1'b1;
      r_busy   <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      r_timer <= (r_state == IDLE) ? 2'd0 : r_timer + 2'd1;
      r_ready <= (r_timer == 2'd2) && w_byte_end && w_payload;
      if (r_timer == 2'd3) begin
        case (r_state)
          SYNC, PID, DATA, CRC: begin
            if (w_to_eop) begin
              r_state  <= EOP_SE0;
              r_bitcnt <= 4'd0;
              r_dp     <= 1'b0;
              r_dn     <= 1'b0;
            end else begin
              r_dp   <= r_dp ^ ~w_bit;
              r_dn   <= r_dn ^ ~w_bit;
              r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
              if (w_crc_upd) r_crc <= crc16_step(r_crc, w_bit);
              // A stuff bit holds the field position.
              if (r_ones != 3'd6) begin
                if (!w_byte_end) begin
                  r_bitcnt <= r_bitcnt + 4'd1;
                end else begin
                  r_bitcnt <= 4'd0;
                  if (r_state == SYNC) begin
                    r_state <= PID;
                  end else if (tx_valid) begin
                    r_state <= DATA;
                    r_shift <= tx_data;
                  end else begin
                    r_state <= CRC;
                  end
                end
              end
            end
          end
          EOP_SE0: begin
            if (r_bitcnt == 4'd1) begin
              r_state <= EOP_J;
              r_dp    <= 1'b1;
              r_dn    <= 1'b0;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
          EOP_J: begin
            r_state <= IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign tx_en    = r_en;
  assign dp_out   = r_dp;
  assign dn_out   = r_dn;

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: a bit-level packet model queues the expected
// per-clock {busy,en,dp,dn,ready}; a monitor pops and compares every cycle.
module tb_usb_tx;

  logic       clk_48 = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'd0;
  logic       tx_crc16 = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_en, dp_out, dn_out;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int rdy_cnt = 0;
  bit mon_en = 1'b0;
  bit rdy_seen = 1'b0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_act, mon_exp;
  logic [7:0] stim_bytes[$];
  logic [7:0] cur_bytes[$];
  int cur_idx = 0;

  usb_tx dut (
    .clk_48(clk_48), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid),
    .tx_crc16(tx_crc16), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_en(tx_en),
    .dp_out(dp_out), .dn_out(dn_out)
  );

  always #5 clk_48 = ~clk_48;

  task automatic present();
    tx_valid = (cur_idx < cur_bytes.size());
    tx_data  = tx_valid ? cur_bytes[cur_idx] : 8'($urandom);
  endtask

  // Byte feeder: advance to the next byte after every tx_ready edge.
  always begin
    @(negedge clk_48);
    rdy_seen = tx_ready;
    @(posedge clk_48);
    #1;
    if (rdy_seen) cur_idx++;
    present();
  end

  // Monitor: one comparison per clock; an empty queue means an idle bus.
  always @(negedge clk_48) begin
    if (mon_en) begin
      mon_act = {tx_busy, tx_en, dp_out, dn_out, tx_ready};
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00100;
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL line t=%0t busy/en/dp/dn/rdy got %b expected %b", $time, mon_act, mon_exp);
      end
      if (tx_busy) busy_cnt++;
      if (tx_ready) rdy_cnt++;
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  // Model: field bits, then stuffing, then NRZI, then 4 clocks per bit.
  task automatic issue(input logic [3:0] pid, input logic crc_en);
    bit raw_b[$];
    bit raw_e[$];
    bit out_b[$];
    bit out_r[$];
    logic [15:0] c;
    logic lvl;
    int ones;
    for (int i = 0; i < 8; i++) begin raw_b.push_back(i == 7); raw_e.push_back(1'b0); end
    for (int i = 0; i < 8; i++) begin
      raw_b.push_back((i < 4) ? pid[i] : ~pid[i-4]);
      raw_e.push_back(i == 7);
    end
    // CRC in the non-reflected MSB-first form; its MSB is the first bit sent.
    c = 16'hFFFF;
    foreach (stim_bytes[k]) begin
      for (int i = 0; i < 8; i++) begin
        raw_b.push_back(stim_bytes[k][i]);
        raw_e.push_back(i == 7);
        c = (c[15] ^ stim_bytes[k][i]) ? ((c << 1) ^ 16'h8005) : (c << 1);
      end
    end
    if (crc_en) begin
      for (int i = 15; i >= 0; i--) begin raw_b.push_back(~c[i]); raw_e.push_back(1'b0); end
    end
    ones = 0;
    foreach (raw_b[i]) begin
      out_b.push_back(raw_b[i]);
      out_r.push_back(raw_e[i]);
      ones = raw_b[i] ? ones + 1 : 0;
      if (ones == 6) begin
        out_r[out_r.size()-1] = 1'b0;
        out_b.push_back(1'b0);
        out_r.push_back(raw_e[i]);
        ones = 0;
      end
    end
    @(negedge clk_48);
    #1;
    tx_pid = pid;
    tx_crc16 = crc_en;
    tx_start = 1'b1;
    cur_bytes = stim_bytes;
    cur_idx = 0;
    present();
    lvl = 1'b1;
    foreach (out_b[i]) begin
      if (!out_b[i]) lvl = ~lvl;
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 1'b1, lvl, ~lvl, ((k == 3) && out_r[i])});
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(5'b11000);
    for (int k = 0; k < 4; k++) exp_q.push_back(5'b11100);
    @(posedge clk_48);
    #1;
    tx_start = 1'b0;
    tx_pid = 4'($urandom);
    tx_crc16 = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 4000) begin
      @(negedge clk_48);
      #1;
      k++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s timeout: %0d symbols still expected", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({dp_out, dn_out, tx_en, tx_busy, tx_ready} !== 5'b10000) begin
      errors++;
      $display("FAIL %s dp/dn/en/busy/rdy got %b expected 10000", name,
               {dp_out, dn_out, tx_en, tx_busy, tx_ready});
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_48);
    #1 rst = 1'b0;
    @(negedge clk_48);
    check_idle("reset_state");
    #1 mon_en = 1'b1;

    // ACK
    stim_bytes = {};
    busy_cnt = 0; rdy_cnt = 0;
    issue(4'h2, 1'b0);
    wait_done("ack");
    check_int("ack_busy_cycles", busy_cnt, 76);
    check_int("ack_ready_pulses", rdy_cnt, 1);

    // Zero-length DATA0 with CRC
    busy_cnt = 0;
    issue(4'h3, 1'b1);
    wait_done("data0_empty");
    check_int("data0_empty_busy", busy_cnt, 140);

    // One 0xFF byte forces a stuff bit
    stim_bytes = {8'hFF};
    busy_cnt = 0; rdy_cnt = 0;
    issue(4'h3, 1'b0);
    wait_done("stuff_ff");
    check_int("stuff_busy", busy_cnt, 112);
    check_int("stuff_ready_pulses", rdy_cnt, 2);

    // DATA1 00 01 02 03 with CRC
    stim_bytes = {8'h00, 8'h01, 8'h02, 8'h03};
    rdy_cnt = 0;
    issue(4'hB, 1'b1);
    wait_done("data1_4b");
    check_int("data1_ready_pulses", rdy_cnt, 5);

    // A start 20 cycles into an ACK is dropped
    stim_bytes = {};
    busy_cnt = 0;
    issue(4'h2, 1'b0);
    repeat (20) @(posedge clk_48);
    #1 tx_start = 1'b1; tx_pid = 4'h5;
    @(posedge clk_48);
    #1 tx_start = 1'b0;
    wait_done("busy_reject");
    repeat (40) @(negedge clk_48);
    check_int("busy_reject_busy", busy_cnt, 76);

    // Start on the last busy cycle chains the next packet with no gap
    stim_bytes = {};
    issue(4'h2, 1'b0);
    repeat (75) @(posedge clk_48);
    stim_bytes = {8'h7E, 8'hFF};
    issue(4'hB, 1'b1);
    wait_done("back_to_back");

    // Randomized packets
    for (int p = 0; p < 14; p++) begin
      int n;
      n = $urandom_range(0, 6);
      stim_bytes = {};
      for (int b = 0; b < n; b++)
        stim_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      issue(4'($urandom), 1'($urandom));
      wait_done("random_pkt");
      repeat ($urandom_range(0, 5)) @(posedge clk_48);
    end

    // Reset in the middle of DATA aborts with no EOP
    stim_bytes = {8'hA5, 8'h3C, 8'h0F, 8'hF0};
    issue(4'h3, 1'b1);
    repeat (80) @(posedge clk_48);
    @(negedge clk_48);
    #1 rst = 1'b1;
    exp_q.delete();
    cur_bytes.delete();
    cur_idx = 0;
    present();
    repeat (3) @(posedge clk_48);
    #1 rst = 1'b0;
    @(negedge clk_48);
    check_idle("reset_mid_data");
    repeat (30) @(negedge clk_48);
    check_idle("post_reset_idle");

    // Packet after abort is clean
    stim_bytes = {8'h55};
    issue(4'h3, 1'b1);
    wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
